// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI target block.
// State encoding and the idle fill byte returned when nothing is queued.
package spi_pkg;

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    ACTIVE
  } state_t;

  localparam logic [7:0] IDLE_FILL = 8'hFF;

endpackage

// File: rtl/sync_edge.sv
// Input synchronizer with registered rise/fall pulses.
// The pulses lag the synchronized level by one clk.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic resetq,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  assign q = chain[STAGES-1];

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      chain <= '0;
      prev  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= (chain << 1) | STAGES'(d);
      prev  <= q;
      rise  <= q & ~prev;
      fall  <= ~q & prev;
    end
  end

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target: one byte in, one byte out per 8 sck cycles.
// Bus pins are oversampled by clk; nothing uses the raw pins directly.
module spi_target
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic       sck,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic       wr,
  input  logic [7:0] tx_data,
  input  logic       rd,
  output logic [7:0] rx_data,
  output logic       valid,
  output logic       busy,
  output logic       overrun
);

  logic                   sck_s;
  logic                   sck_rise;
  logic                   sck_fall;
  logic [SYNC_STAGES-1:0] cs_chain;
  logic [SYNC_STAGES-1:0] mosi_chain;
  logic                   cs_s;
  logic                   mosi_s;
  logic [SYNC_STAGES:0]   armed;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] rx_shift;
  logic [7:0] tx_shift;
  logic [7:0] hold;
  logic       done;
  logic       reload;
  logic [7:0] reload_byte;

  sync_edge #(
    .STAGES(SYNC_STAGES)
  ) u_sck (
    .clk   (clk),
    .resetq(resetq),
    .d     (sck),
    .q     (sck_s),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  assign cs_s   = cs_chain[SYNC_STAGES-1];
  assign mosi_s = mosi_chain[SYNC_STAGES-1];
  assign miso   = tx_shift[7];

  // armed keeps WAIT_IDLE from trusting the reset value of the cs chain
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      cs_chain   <= '1;
      mosi_chain <= '0;
      armed      <= '0;
    end else begin
      cs_chain   <= (cs_chain << 1) | SYNC_STAGES'(cs_n);
      mosi_chain <= (mosi_chain << 1) | SYNC_STAGES'(mosi);
      armed      <= {armed[SYNC_STAGES-1:0], 1'b1};
    end
  end

  always_comb begin
    reload      = 1'b0;
    reload_byte = busy ? hold : IDLE_FILL;
    unique case (1'b1)
      (state == IDLE) && !cs_s:
        reload = 1'b1;
      (state == ACTIVE) && !cs_s && sck_fall && (bit_cnt == 3'd0):
        reload = 1'b1;
      default:
        reload = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state    <= WAIT_IDLE;
      bit_cnt  <= 3'd0;
      rx_shift <= 8'h00;
      tx_shift <= IDLE_FILL;
      hold     <= 8'h00;
      rx_data  <= 8'h00;
      valid    <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
      miso_oe  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        WAIT_IDLE: begin
          if (armed[SYNC_STAGES] && cs_s)
            state <= IDLE;
        end
        IDLE: begin
          if (!cs_s) begin
            state    <= ACTIVE;
            miso_oe  <= 1'b1;
            bit_cnt  <= 3'd0;
            tx_shift <= reload_byte;
          end
        end
        ACTIVE: begin
          if (cs_s) begin
            state   <= IDLE;
            miso_oe <= 1'b0;
            bit_cnt <= 3'd0;
          end else if (sck_rise) begin
            rx_shift <= {rx_shift[6:0], mosi_s};
            bit_cnt  <= bit_cnt + 3'd1;
            done     <= (bit_cnt == 3'd7);
          end else if (sck_fall) begin
            tx_shift <= (bit_cnt == 3'd0) ? reload_byte
                                          : {tx_shift[6:0], 1'b1};
          end
        end
        default: state <= WAIT_IDLE;
      endcase

      // a reload empties the holding register before wr can refill it
      if (reload) begin
        busy <= wr;
        if (wr)
          hold <= tx_data;
      end else if (wr && !busy) begin
        busy <= 1'b1;
        hold <= tx_data;
      end

      if (done) begin
        rx_data <= rx_shift;
        valid   <= 1'b1;
        overrun <= rd ? 1'b0 : (overrun | valid);
      end else if (rd) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end

endmodule
